bht_update_gen: RTL and testbench
=================================

// Module: bht_update_gen
// PURPOSE
// - Producer side of the BHT update interface: tracks in-flight branch predictions and emits one
//   ariane_pkg::bht_update_t per resolved branch, plus a mispredict flag and global history.
// - Sits between frontend (pushes predictions in fetch order) and branch unit (resolves in order).
// - Maintains speculative and committed global history registers (GHR); restores on mispredict/flush.
// PARAMETERS
// - DEPTH     8   in-flight prediction FIFO entries; power of 2, >=2
// - GHR_BITS  10  global history length
// PORTS
// - clk_i               in   1                      clock, all state on rising edge
// - rst_i               in   1                      reset, asynchronous, active-high
// - flush_i             in   1                      discard all in-flight predictions
// - debug_mode_i        in   1                      suppress BHT training
// - pred_valid_i        in   1                      frontend pushes a prediction
// - pred_ready_o        out  1                      = !full; push accepted on valid&&ready
// - pred_pc_i           in   riscv::VLEN            branch PC
// - pred_taken_i        in   1                      predicted direction
// - res_valid_i         in   1                      oldest branch resolved this cycle
// - res_taken_i         in   1                      actual direction
// - bht_update_o        out  ariane_pkg::bht_update_t  {valid, pc, taken}, registered
// - mispredict_o        out  1                      registered, same cycle as bht_update_o.valid
// - underflow_o         out  1                      registered pulse: res_valid_i with FIFO empty
// - count_o             out  $clog2(DEPTH)+1        entries in flight
// - ghr_spec_o          out  GHR_BITS               speculative history (for index hashing)
// BEHAVIOUR
// - Reset: FIFO empty, count_o=0, pred_ready_o=1, bht_update_o='0, mispredict_o=0,
//   underflow_o=0, both GHRs=0.
// - Push: pred_valid_i&&pred_ready_o -> write {pc,taken} at tail; ghr_spec <= {ghr_spec[GHR_BITS-2:0],pred_taken_i}.
// - Resolve (res_valid_i, count!=0): pop head; next cycle bht_update_o.valid=!debug_mode_i,
//   .pc=head pc, .taken=res_taken_i; mispredict_o=(head taken!=res_taken_i) regardless of debug.
//   ghr_commit <= {ghr_commit[GHR_BITS-2:0],res_taken_i}.
// - Latency: resolve -> update exactly 1 cycle; outputs single-cycle pulses, 0 otherwise.
// - Mispredict: all younger entries discarded (wrong path): count->0, ghr_spec <= new ghr_commit
//   value (including this resolution). A push in the same cycle is dropped.
// - Correct prediction + push same cycle: both happen; count unchanged. Push uses pre-pop full,
//   so with FIFO full pred_ready_o=0 even if a pop occurs that cycle.
// - Resolve with FIFO empty: no update, no GHR change, underflow_o=1 next cycle.
// - flush_i: highest priority; FIFO emptied, ghr_spec <= ghr_commit (current value), any same-cycle
//   push and resolve dropped, bht_update_o.valid=0 next cycle. ghr_commit unchanged.
// - Pointers wrap modulo DEPTH; count_o saturates by construction at DEPTH (full).
// - Reset asserted mid-operation clears all state asynchronously; in-flight update pulse lost.
// CONFIGURATION
// - BHT_UPD_PERF_CNT_EN defined: adds outputs perf_branches_o[31:0], perf_mispred_o[31:0];
//   increment on each valid resolution / each mispredict (debug mode included), wrap at 2^32,
//   cleared only by rst_i (not flush_i).
// - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset then push pc=0x100 T, 0x104 N -> count_o=2, ghr_spec_o=0b10, pred_ready_o=1.
// - Resolve 0x100 actual T -> next cycle bht_update_o={1,0x100,1}, mispredict_o=0, count_o=1.
// - Push 3 entries, resolve head with wrong direction -> mispredict_o=1, count_o=0,
//   ghr_spec_o==ghr_commit incl. new bit; same-cycle push dropped.
// - Fill DEPTH=8 -> pred_ready_o=0; resolve+push same cycle -> push rejected, count_o=7.
// - res_valid_i with empty FIFO -> underflow_o=1 one cycle, no bht_update, GHRs unchanged.
// - debug_mode_i=1 during mispredicted resolve -> bht_update_o.valid=0, mispredict_o=1;
//   flush_i with resolve same cycle -> no update, count_o=0, ghr_spec_o=ghr_commit.

Source files
------------

// File: rtl/bht_update_gen.sv
// BHT update producer: tracks in-flight predictions, emits one bht_update_t per resolved branch,
// with speculative/committed global history. Optional perf counters: BHT_UPD_PERF_CNT_EN.

package riscv;
  localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
  typedef struct packed {
    logic                   valid;
    logic [riscv::VLEN-1:0] pc;
    logic                   taken;
  } bht_update_t;
endpackage

module bht_update_gen #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned GHR_BITS = 10
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          debug_mode_i,
  input  logic                          pred_valid_i,
  output logic                          pred_ready_o,
  input  logic [riscv::VLEN-1:0]        pred_pc_i,
  input  logic                          pred_taken_i,
  input  logic                          res_valid_i,
  input  logic                          res_taken_i,
  output ariane_pkg::bht_update_t       bht_update_o,
  output logic                          mispredict_o,
  output logic                          underflow_o,
`ifdef BHT_UPD_PERF_CNT_EN
  output logic [31:0]                   perf_branches_o,
  output logic [31:0]                   perf_mispred_o,
`endif
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [GHR_BITS-1:0]           ghr_spec_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [riscv::VLEN-1:0] r_pc    [DEPTH];
  logic                   r_taken [DEPTH];
  logic [PTR_W-1:0]       r_head, r_tail;
  logic [CNT_W-1:0]       r_count;
  logic [GHR_BITS-1:0]    r_ghr_spec, r_ghr_commit;

  ariane_pkg::bht_update_t r_upd;
  logic                    r_mis, r_uf;

  logic                    w_full, w_empty;
  logic                    w_push, w_res, w_pop, w_underflow, w_mis;
  logic [GHR_BITS-1:0]     w_ghr_commit_shift;
  logic [PTR_W-1:0]        w_head_nxt, w_tail_nxt;
  logic [CNT_W-1:0]        w_count_nxt;
  logic [GHR_BITS-1:0]     w_ghr_spec_nxt, w_ghr_commit_nxt;
  ariane_pkg::bht_update_t w_upd_nxt;

  // Handshake decode; flush dominates push and resolve, full is the pre-pop value.
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_push      = pred_valid_i && !w_full && !flush_i;
  assign w_res       = res_valid_i && !flush_i;
  assign w_pop       = w_res && !w_empty;
  assign w_underflow = w_res && w_empty;
  assign w_mis       = w_pop && (r_taken[r_head] != res_taken_i);

  assign w_ghr_commit_shift = {r_ghr_commit[GHR_BITS-2:0], res_taken_i};

  // Next-state for pointers, occupancy and history.
  always_comb begin
    w_head_nxt       = r_head;
    w_tail_nxt       = r_tail;
    w_count_nxt      = r_count;
    w_ghr_spec_nxt   = r_ghr_spec;
    w_ghr_commit_nxt = r_ghr_commit;
    w_upd_nxt        = '0;

    if (flush_i) begin
      w_head_nxt     = '0;
      w_tail_nxt     = '0;
      w_count_nxt    = '0;
      w_ghr_spec_nxt = r_ghr_commit;
    end else if (w_mis) begin
      // Wrong path: drop everything younger, rebuild spec history from committed.
      w_head_nxt       = '0;
      w_tail_nxt       = '0;
      w_count_nxt      = '0;
      w_ghr_commit_nxt = w_ghr_commit_shift;
      w_ghr_spec_nxt   = w_ghr_commit_shift;
    end else begin
      if (w_push) begin
        w_tail_nxt     = r_tail + PTR_W'(1);
        w_ghr_spec_nxt = {r_ghr_spec[GHR_BITS-2:0], pred_taken_i};
      end
      if (w_pop) begin
        w_head_nxt       = r_head + PTR_W'(1);
        w_ghr_commit_nxt = w_ghr_commit_shift;
      end
      w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    if (w_pop && !debug_mode_i) begin
      w_upd_nxt.valid = 1'b1;
      w_upd_nxt.pc    = r_pc[r_head];
      w_upd_nxt.taken = res_taken_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_ghr_spec   <= '0;
      r_ghr_commit <= '0;
      r_upd        <= '0;
      r_mis        <= 1'b0;
      r_uf         <= 1'b0;
    end else begin
      r_head       <= w_head_nxt;
      r_tail       <= w_tail_nxt;
      r_count      <= w_count_nxt;
      r_ghr_spec   <= w_ghr_spec_nxt;
      r_ghr_commit <= w_ghr_commit_nxt;
      r_upd        <= w_upd_nxt;
      r_mis        <= w_mis;
      r_uf         <= w_underflow;
    end
  end

  // Payload storage needs no reset; occupancy guards every read.
  always_ff @(posedge clk_i) begin
    if (w_push && !w_mis) begin
      r_pc[r_tail]    <= pred_pc_i;
      r_taken[r_tail] <= pred_taken_i;
    end
  end

`ifdef BHT_UPD_PERF_CNT_EN
  logic [31:0] r_perf_branches, r_perf_mispred;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_branches <= '0;
      r_perf_mispred  <= '0;
    end else begin
      if (w_pop) r_perf_branches <= r_perf_branches + 32'd1;
      if (w_mis) r_perf_mispred  <= r_perf_mispred + 32'd1;
    end
  end

  assign perf_branches_o = r_perf_branches;
  assign perf_mispred_o  = r_perf_mispred;
`endif

  assign pred_ready_o = !w_full;
  assign bht_update_o = r_upd;
  assign mispredict_o = r_mis;
  assign underflow_o  = r_uf;
  assign count_o      = r_count;
  assign ghr_spec_o   = r_ghr_spec;

endmodule

// File: tb/tb_bht_update_gen.sv
// Directed bench for bht_update_gen with hand-computed expectations.

module tb_bht_update_gen;
  import ariane_pkg::*;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   flush_i;
  logic                   debug_mode_i;
  logic                   pred_valid_i;
  logic                   pred_ready_o;
  logic [riscv::VLEN-1:0] pred_pc_i;
  logic                   pred_taken_i;
  logic                   res_valid_i;
  logic                   res_taken_i;
  bht_update_t            bht_update_o;
  logic                   mispredict_o;
  logic                   underflow_o;
  logic [3:0]             count_o;
  logic [9:0]             ghr_spec_o;
`ifdef BHT_UPD_PERF_CNT_EN
  logic [31:0]            perf_branches_o;
  logic [31:0]            perf_mispred_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  bht_update_gen #(.DEPTH(8), .GHR_BITS(10)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .debug_mode_i    (debug_mode_i),
    .pred_valid_i    (pred_valid_i),
    .pred_ready_o    (pred_ready_o),
    .pred_pc_i       (pred_pc_i),
    .pred_taken_i    (pred_taken_i),
    .res_valid_i     (res_valid_i),
    .res_taken_i     (res_taken_i),
    .bht_update_o    (bht_update_o),
    .mispredict_o    (mispredict_o),
    .underflow_o     (underflow_o),
`ifdef BHT_UPD_PERF_CNT_EN
    .perf_branches_o (perf_branches_o),
    .perf_mispred_o  (perf_mispred_o),
`endif
    .count_o         (count_o),
    .ghr_spec_o      (ghr_spec_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    flush_i      = 1'b0;
    debug_mode_i = 1'b0;
    pred_valid_i = 1'b0;
    pred_pc_i    = '0;
    pred_taken_i = 1'b0;
    res_valid_i  = 1'b0;
    res_taken_i  = 1'b0;
  endtask

  task automatic push(input logic [63:0] pc, input logic t);
    pred_valid_i = 1'b1;
    pred_pc_i    = pc;
    pred_taken_i = t;
    step();
    pred_valid_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #1;
    check("rst_count",  64'(count_o), 64'd0);
    check("rst_ready",  64'(pred_ready_o), 64'd1);
    check("rst_valid",  64'(bht_update_o.valid), 64'd0);
    check("rst_mis",    64'(mispredict_o), 64'd0);
    check("rst_uf",     64'(underflow_o), 64'd0);
    check("rst_ghr",    64'(ghr_spec_o), 64'd0);

    // Two pushes: T then N
    push(64'h100, 1'b1);
    push(64'h104, 1'b0);
    check("push2_count", 64'(count_o), 64'd2);
    check("push2_ghr",   64'(ghr_spec_o), 64'h2);
    check("push2_ready", 64'(pred_ready_o), 64'd1);

    // Correct resolve of 0x100
    res_valid_i = 1'b1; res_taken_i = 1'b1;
    step();
    res_valid_i = 1'b0;
    check("res1_valid", 64'(bht_update_o.valid), 64'd1);
    check("res1_pc",    64'(bht_update_o.pc), 64'h100);
    check("res1_taken", 64'(bht_update_o.taken), 64'd1);
    check("res1_mis",   64'(mispredict_o), 64'd0);
    check("res1_count", 64'(count_o), 64'd1);
    step();
    check("res1_pulse", 64'(bht_update_o.valid), 64'd0);

    // Three more pushes; spec 0x2 -> 0x5 -> 0xB -> 0x16
    push(64'h200, 1'b1);
    push(64'h204, 1'b1);
    push(64'h208, 1'b0);
    check("push3_count", 64'(count_o), 64'd4);
    check("push3_ghr",   64'(ghr_spec_o), 64'h16);

    // Head 0x104 predicted N, actual T, with a dropped same-cycle push
    res_valid_i = 1'b1; res_taken_i = 1'b1;
    pred_valid_i = 1'b1; pred_pc_i = 64'h20C; pred_taken_i = 1'b1;
    step();
    idle_inputs();
    check("mis_flag",  64'(mispredict_o), 64'd1);
    check("mis_valid", 64'(bht_update_o.valid), 64'd1);
    check("mis_pc",    64'(bht_update_o.pc), 64'h104);
    check("mis_count", 64'(count_o), 64'd0);
    check("mis_ghr",   64'(ghr_spec_o), 64'h3);
    step();
    check("mis_pulse", 64'(mispredict_o), 64'd0);

    // Fill all 8; spec 0x3 shifted by 1,0,1,0,1,0,1,0 -> 0x3AA
    for (int i = 0; i < 8; i++) push(64'h300 + 64'(4 * i), (i % 2) == 0);
    check("full_count", 64'(count_o), 64'd8);
    check("full_ready", 64'(pred_ready_o), 64'd0);
    check("full_ghr",   64'(ghr_spec_o), 64'h3AA);

    // Correct resolve plus push while full: push rejected
    res_valid_i = 1'b1; res_taken_i = 1'b1;
    pred_valid_i = 1'b1; pred_pc_i = 64'h400; pred_taken_i = 1'b0;
    step();
    idle_inputs();
    check("fullpop_count", 64'(count_o), 64'd7);
    check("fullpop_pc",    64'(bht_update_o.pc), 64'h300);
    check("fullpop_mis",   64'(mispredict_o), 64'd0);
    check("fullpop_ghr",   64'(ghr_spec_o), 64'h3AA);
    check("fullpop_ready", 64'(pred_ready_o), 64'd1);

    // Flush with same-cycle resolve: commit is 0x7
    flush_i = 1'b1; res_valid_i = 1'b1; res_taken_i = 1'b0;
    step();
    idle_inputs();
    check("flush_valid", 64'(bht_update_o.valid), 64'd0);
    check("flush_mis",   64'(mispredict_o), 64'd0);
    check("flush_count", 64'(count_o), 64'd0);
    check("flush_ghr",   64'(ghr_spec_o), 64'h7);

    // Resolve while empty
    res_valid_i = 1'b1; res_taken_i = 1'b0;
    step();
    idle_inputs();
    check("uf_flag",  64'(underflow_o), 64'd1);
    check("uf_valid", 64'(bht_update_o.valid), 64'd0);
    check("uf_ghr",   64'(ghr_spec_o), 64'h7);
    step();
    check("uf_pulse", 64'(underflow_o), 64'd0);

    // Debug-mode mispredict; commit 0x7 -> 0xE proves it was untouched above
    push(64'h500, 1'b1);
    check("dbg_push_ghr", 64'(ghr_spec_o), 64'hF);
    debug_mode_i = 1'b1; res_valid_i = 1'b1; res_taken_i = 1'b0;
    step();
    idle_inputs();
    check("dbg_valid", 64'(bht_update_o.valid), 64'd0);
    check("dbg_mis",   64'(mispredict_o), 64'd1);
    check("dbg_count", 64'(count_o), 64'd0);
    check("dbg_ghr",   64'(ghr_spec_o), 64'hE);

`ifdef BHT_UPD_PERF_CNT_EN
    check("perf_branches", 64'(perf_branches_o), 64'd4);
    check("perf_mispred",  64'(perf_mispred_o), 64'd2);
`endif

    // Asynchronous reset mid-operation
    push(64'h600, 1'b1);
    push(64'h604, 1'b1);
    check("pre_rst_count", 64'(count_o), 64'd2);
    #2;
    rst_i = 1'b1;
    #1;
    check("async_rst_count", 64'(count_o), 64'd0);
    check("async_rst_ghr",   64'(ghr_spec_o), 64'd0);
    rst_i = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
